// File: rtl/vga_framebuffer_sink.sv
// Pixel-write sink: 160x120x3 framebuffer that clears itself after reset,
// scanned out as 640x480@60Hz VGA with 4x4 pixel replication.
module vga_framebuffer_sink #(
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter int         FB_WIDTH     = 160,
    parameter int         FB_HEIGHT    = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       ready,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    localparam int          FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(FB_DEPTH - 1);
    localparam logic [7:0]  FB_W8     = 8'(FB_WIDTH);
    localparam logic [7:0]  FB_H8     = 8'(FB_HEIGHT);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]  state_reg;
    logic [14:0] clr_addr_reg;
    logic        ready_reg;
    logic        pix_en_reg;
    logic [9:0]  h_count_reg;
    logic [9:0]  v_count_reg;

    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic [14:0] pix_addr;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data_reg;

    logic        visible;
    logic        hs_raw;
    logic        vs_raw;
    logic        vis_d1_reg, hs_d1_reg, vs_d1_reg;
    logic        blank_n_reg, hs_reg, vs_reg;
    logic [2:0]  rgb_reg;

    logic [2:0]  fb_mem [0:FB_DEPTH-1];

    // Row stride of 160 expressed as (y<<7)+(y<<5) so no multiplier is needed.
    assign pix_addr = {y, 7'b0} + {2'b0, y, 5'b0} + {7'b0, x};

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr_reg;
        wr_data = CLEAR_COLOUR;
        if (state_reg == ST_CLEAR) begin
            wr_en = 1'b1;
        end else if (plot && (x < FB_W8) && (y < FB_H8)) begin
            wr_en   = 1'b1;
            wr_addr = pix_addr;
            wr_data = colour;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
            ready_reg    <= 1'b0;
        end else if (state_reg == ST_CLEAR) begin
            clr_addr_reg <= clr_addr_reg + 15'd1;
            if (clr_addr_reg == LAST_ADDR) begin
                state_reg <= ST_RUN;
                ready_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pix_en_reg  <= 1'b0;
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else begin
            pix_en_reg <= ~pix_en_reg;
            if (pix_en_reg) begin
                if (h_count_reg == 10'd799) begin
                    h_count_reg <= '0;
                    v_count_reg <= (v_count_reg == 10'd524) ? 10'd0 : v_count_reg + 10'd1;
                end else begin
                    h_count_reg <= h_count_reg + 10'd1;
                end
            end
        end
    end

    assign visible = (h_count_reg < 10'd640) && (v_count_reg < 10'd480);
    assign hs_raw  = !((h_count_reg >= 10'd656) && (h_count_reg <= 10'd751));
    assign vs_raw  = !((v_count_reg == 10'd490) || (v_count_reg == 10'd491));

    // Blanked positions read address 0 so the index never leaves the array.
    assign rd_addr = visible ? ({v_count_reg[9:2], 7'b0} + {2'b0, v_count_reg[9:2], 5'b0}
                               + {7'b0, h_count_reg[9:2]}) : 15'd0;

    // Write and read in one block: a same-address collision returns old data.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= wr_data;
        end
        if (pix_en_reg) begin
            rd_data_reg <= fb_mem[rd_addr];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vis_d1_reg  <= 1'b0;
            hs_d1_reg   <= 1'b1;
            vs_d1_reg   <= 1'b1;
            blank_n_reg <= 1'b0;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            rgb_reg     <= '0;
        end else if (pix_en_reg) begin
            vis_d1_reg  <= visible;
            hs_d1_reg   <= hs_raw;
            vs_d1_reg   <= vs_raw;
            blank_n_reg <= vis_d1_reg;
            hs_reg      <= hs_d1_reg;
            vs_reg      <= vs_d1_reg;
            rgb_reg     <= vis_d1_reg ? rd_data_reg : 3'b000;
        end
    end

    assign ready       = ready_reg;
    assign VGA_CLK     = pix_en_reg;
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLANK_N = blank_n_reg;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = {10{rgb_reg[2]}};
    assign VGA_G       = {10{rgb_reg[1]}};
    assign VGA_B       = {10{rgb_reg[0]}};

endmodule
